poly_voice_engine: RTL and testbench
====================================

# poly_voice_engine

Polyphonic note-to-sample engine. It replaces the single-note, single-phase-accumulator datapath with `voices_p` independently allocated voices. Note-on/off events arrive over a valid/ready handshake. On each sample strobe the engine steps every voice's phase, generates the selected waveform arithmetically, applies an optional per-voice envelope, and emits one averaged signed mix sample. It sits between the keypad decoder (event source) and the audio output register.

## Interface
- `voices_p`, 4: voice count; power of two, 1..16
- `width_p`, 24: output/waveform sample width
- `acc_width_p`, 32: phase accumulator width (≥ `width_p`)
- `sample_rate_p`, 48000: sample rate in Hz, used for the phase-increment table
- `attack_step_p`, 16: envelope gain increment per sample (ENVELOPE_EN only)
- `release_step_p`, 4: envelope gain decrement per sample (ENVELOPE_EN only)

Ports:
- `clk_i` in 1: single clock
- `reset_i` in 1: reset, asynchronous, active-high
- `evt_valid_i` in 1: event valid
- `evt_ready_o` out 1: event accepted when valid&ready
- `evt_on_i` in 1: 1 = note-on, 0 = note-off
- `evt_note_i` in 4: note index 0..15
- `mode_i` in 2: 0 saw, 1 square, 2 triangle, 3 silence; sampled on accepted `sample_en_i`
- `sample_en_i` in 1: one-cycle sample strobe
- `sample_o` out `width_p` signed: mixed sample
- `valid_o` out 1: one-cycle pulse, `sample_o` updated
- `active_o` out `voices_p`: per-voice busy bitmap
- `overrun_o` out 1: one-cycle pulse, strobe dropped

## Operation
- Note table (Hz, index 0..15): 261, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1046, 1174.
- Phase increment: inc[n] = floor(f[n]·2^acc_width_p / sample_rate_p), constant at elaboration.
- Per voice state: active, releasing, note[3:0], phase[acc_width_p-1:0], gain[8:0].
- Note-on:
  - If an active voice holds the same note, retrigger it: phase ← 0, releasing ← 0.
  - Otherwise take the lowest-index inactive voice: phase ← 0.
  - If all voices are active, steal voice `steal_ptr` and advance `steal_ptr` modulo `voices_p`.
- Note-off:
  - The lowest-index active, non-releasing voice with a matching note enters release.
  - If no voice matches, the event is ignored.
- Waveform from P = phase[acc_width_p-1 -: width_p], with MAX = 2^(width_p-1)-1:
  - saw: P with MSB inverted, read as signed.
  - square: +MAX if P MSB = 0, else -MAX.
  - triangle: MSB clear → (P<<1) with MSB inverted; MSB set → (~P<<1) with MSB inverted.
  - silence: 0.
- Each voice uses its current phase, then phase += inc (wraps modulo 2^acc_width_p).
- Contribution = (wave·gain) >>> 8. Inactive voices contribute 0.
- Mix = sum of contributions in `width_p`+log2(`voices_p`) bits. `sample_o` = sum >>> log2(`voices_p`), arithmetic shift, no saturation needed.
- FSM:
  - IDLE: `evt_ready_o`=1. Events are processed the cycle they are accepted. `sample_en_i` → ACCUM, accumulator cleared. If an event and a strobe coincide, the event is applied first, then the strobe is taken.
  - ACCUM: lasts `voices_p` cycles, voice k processed in cycle k. `evt_ready_o`=0; a strobe here pulses `overrun_o` and is dropped.
  - OUT: one cycle. Registers `sample_o`, pulses `valid_o`, returns to IDLE. `evt_ready_o`=0.

## Timing
- Reset values: `sample_o`=0, `valid_o`=0, `active_o`=0, `overrun_o`=0, `evt_ready_o`=1, `steal_ptr`=0, all voice state cleared, FSM in IDLE.
- Reset mid-ACCUM aborts the sample; no `valid_o` is issued.
- `valid_o` asserts exactly `voices_p`+1 cycles after the accepting `sample_en_i` edge.
- The minimum strobe spacing is `voices_p`+2 cycles. Strobes at 48 kHz are far slower.
- `active_o` updates the cycle after the event is accepted.
- Envelope/gain updates happen after a voice's contribution is computed in ACCUM, so the new gain applies from the next sample.

## Configuration
- `POLY_VOICE_ENVELOPE_EN` defined:
  - Note-on sets gain ← 0. Each sample, gain += `attack_step_p`, saturating at 256.
  - In release, gain -= `release_step_p` per sample, floored at 0.
  - A voice with releasing=1 and gain=0 after update goes inactive.
- `POLY_VOICE_ENVELOPE_EN` undefined:
  - gain is 256 while active.
  - Note-off deactivates the voice immediately, on the cycle after acceptance.
  - `attack_step_p`/`release_step_p` are unused.

## Test plan
All value checks use `voices_p`=4, `width_p`=24, and the build without the macro unless stated.
- Reset then strobe, no notes → `valid_o` 5 cycles later, `sample_o`=0, `active_o`=0000.
- Note-on 5, mode 0, two strobes:
  - First `sample_o` = -2097152.
  - Second = (((39370533>>8) - 8388608) >>> 2) = -2058705.
- Note-on 5, mode 1, one strobe → `sample_o`=2097151.
- Note-ons 0,1,2,3,4 → `active_o`=1111; voice 0 holds note 4. Note-off 7 → no change. Note-off 1 → `active_o`=1101.
- A strobe during ACCUM → `overrun_o` pulses; exactly one `valid_o` follows. An event during ACCUM is held by `evt_ready_o`=0 until IDLE.
- With `POLY_VOICE_ENVELOPE_EN`, note-on 5, mode 1:
  - Sample outputs are 0, then (8388607·16>>>8)>>>2 = 131071.
  - After note-off, the voice stays active until gain reaches 0.

Source files
------------

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: polyphonic note-to-sample engine.
// Note events allocate voices; each sample strobe walks the voices one per
// cycle, accumulates their waveforms and emits the averaged mix.
// Optional feature macro: POLY_VOICE_ENVELOPE_EN (attack/release envelope).
module poly_voice_engine #(
    parameter int voices_p       = 4,
    parameter int width_p        = 24,
    parameter int acc_width_p    = 32,
    parameter int sample_rate_p  = 48000,
    parameter int attack_step_p  = 16,
    parameter int release_step_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      evt_valid_i,
    output logic                      evt_ready_o,
    input  logic                      evt_on_i,
    input  logic [3:0]                evt_note_i,
    input  logic [1:0]                mode_i,
    input  logic                      sample_en_i,
    output logic signed [width_p-1:0] sample_o,
    output logic                      valid_o,
    output logic [voices_p-1:0]       active_o,
    output logic                      overrun_o
);
    localparam int LOG_V = $clog2(voices_p);
    localparam int IDX_W = (LOG_V > 0) ? LOG_V : 1;
    localparam int SUM_W = width_p + LOG_V;
    localparam logic [8:0] GAIN_FULL = 9'd256;
`ifdef POLY_VOICE_ENVELOPE_EN
    localparam logic [8:0] GAIN_ON = 9'd0;
`else
    localparam logic [8:0] GAIN_ON = GAIN_FULL;
`endif

    if (voices_p < 1 || voices_p > 16 || acc_width_p < width_p ||
        attack_step_p < 0 || release_step_p < 0) begin : g_bad_params
        $error("poly_voice_engine: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    // Phase increment for note n: floor(f * 2^acc_width_p / sample_rate_p).
    function automatic logic [acc_width_p-1:0] calc_inc(input int n);
        int unsigned f;
        logic [63:0] num;
        case (n)
            0: f = 261;   1: f = 294;   2: f = 330;   3: f = 349;
            4: f = 392;   5: f = 440;   6: f = 494;   7: f = 523;
            8: f = 587;   9: f = 659;   10: f = 698;  11: f = 784;
            12: f = 880;  13: f = 988;  14: f = 1046; default: f = 1174;
        endcase
        num = 64'(f) << acc_width_p;
        return acc_width_p'(num / 64'(sample_rate_p));
    endfunction

    // Arithmetic waveform from the top width_p bits of the phase.
    function automatic logic signed [width_p-1:0] wave_gen(input logic [1:0] mode,
                                                           input logic [width_p-1:0] p);
        logic [width_p-2:0] t;
        logic [width_p-1:0] s;
        logic [width_p-1:0] w;
        t = p[width_p-1] ? ~p[width_p-2:0] : p[width_p-2:0];
        s = {t, 1'b0};
        case (mode)
            2'd0:    w = {~p[width_p-1], p[width_p-2:0]};
            2'd1:    w = p[width_p-1] ? {1'b1, {(width_p-2){1'b0}}, 1'b1}
                                      : {1'b0, {(width_p-1){1'b1}}};
            2'd2:    w = {~s[width_p-1], s[width_p-2:0]};
            default: w = '0;
        endcase
        return $signed(w);
    endfunction

    // Scale by gain (256 = unity); the result always fits width_p bits.
    function automatic logic signed [width_p-1:0] apply_gain(input logic signed [width_p-1:0] w,
                                                             input logic [8:0] g);
        logic signed [width_p+9:0] prod;
        prod = w * $signed({1'b0, g});
        return width_p'(prod >>> 8);
    endfunction

    logic [acc_width_p-1:0] inc_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_inc
        assign inc_tab[g] = calc_inc(g);
    end

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         vidx_q, vidx_d, steal_q, steal_d;
    logic [1:0]               mode_q, mode_d;
    logic signed [SUM_W-1:0]  acc_q, acc_d;
    logic signed [width_p-1:0] sample_q, sample_d;
    logic                     valid_q, valid_d, overrun_q, overrun_d;
    logic [voices_p-1:0]      act_q, act_d, rel_q, rel_d;
    logic [3:0]               note_q  [voices_p];
    logic [3:0]               note_d  [voices_p];
    logic [acc_width_p-1:0]   phase_q [voices_p];
    logic [acc_width_p-1:0]   phase_d [voices_p];
    logic [8:0]               gain_q  [voices_p];
    logic [8:0]               gain_d  [voices_p];

    logic                     on_hit, free_hit, off_hit;
    logic [IDX_W-1:0]         on_idx, free_idx, off_idx, sel_idx;
    logic signed [width_p-1:0] wave_c, contrib_c;
`ifdef POLY_VOICE_ENVELOPE_EN
    logic [9:0]               gain_sum_c;
`endif

    // State and voice registers; reset clears everything and aborts a sample.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            vidx_q    <= '0;
            steal_q   <= '0;
            mode_q    <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            act_q     <= '0;
            rel_q     <= '0;
            for (int i = 0; i < voices_p; i++) begin
                note_q[i]  <= '0;
                phase_q[i] <= '0;
                gain_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            vidx_q    <= vidx_d;
            steal_q   <= steal_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            act_q     <= act_d;
            rel_q     <= rel_d;
            note_q    <= note_d;
            phase_q   <= phase_d;
            gain_q    <= gain_d;
        end
    end

    // Next state: event allocation in IDLE, per-voice accumulate in ACCUM, output in OUT.
    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        steal_d     = steal_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        overrun_d   = sample_en_i && (state_q != IDLE);
        act_d       = act_q;
        rel_d       = rel_q;
        note_d      = note_q;
        phase_d     = phase_q;
        gain_d      = gain_q;
        evt_ready_o = 1'b0;
        wave_c      = '0;
        contrib_c   = '0;
        sel_idx     = '0;
`ifdef POLY_VOICE_ENVELOPE_EN
        gain_sum_c  = '0;
`endif
        on_hit = 1'b0;  on_idx = '0;
        free_hit = 1'b0; free_idx = '0;
        off_hit = 1'b0; off_idx = '0;
        for (int i = 0; i < voices_p; i++) begin
            if (!on_hit && act_q[i] && note_q[i] == evt_note_i) begin
                on_hit = 1'b1;
                on_idx = IDX_W'(i);
            end
            if (!free_hit && !act_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (!off_hit && act_q[i] && !rel_q[i] && note_q[i] == evt_note_i) begin
                off_hit = 1'b1;
                off_idx = IDX_W'(i);
            end
        end

        case (state_q)
            IDLE: begin
                evt_ready_o = 1'b1;
                if (evt_valid_i) begin
                    if (evt_on_i) begin
                        if (on_hit) begin
                            sel_idx = on_idx;
                        end else if (free_hit) begin
                            sel_idx = free_idx;
                        end else begin
                            sel_idx = steal_q;
                            steal_d = (steal_q == IDX_W'(voices_p - 1)) ? '0
                                                                       : steal_q + IDX_W'(1);
                        end
                        act_d[sel_idx]   = 1'b1;
                        rel_d[sel_idx]   = 1'b0;
                        note_d[sel_idx]  = evt_note_i;
                        phase_d[sel_idx] = '0;
                        gain_d[sel_idx]  = GAIN_ON;
                    end else if (off_hit) begin
`ifdef POLY_VOICE_ENVELOPE_EN
                        rel_d[off_idx] = 1'b1;
`else
                        act_d[off_idx] = 1'b0;
`endif
                    end
                end
                if (sample_en_i) begin
                    state_d = ACCUM;
                    vidx_d  = '0;
                    acc_d   = '0;
                    mode_d  = mode_i;
                end
            end
            ACCUM: begin
                if (act_q[vidx_q]) begin
                    wave_c    = wave_gen(mode_q, phase_q[vidx_q][acc_width_p-1 -: width_p]);
                    contrib_c = apply_gain(wave_c, gain_q[vidx_q]);
                    acc_d     = acc_q + SUM_W'(contrib_c);
                    phase_d[vidx_q] = phase_q[vidx_q] + inc_tab[note_q[vidx_q]];
`ifdef POLY_VOICE_ENVELOPE_EN
                    if (rel_q[vidx_q]) begin
                        if (gain_q[vidx_q] > 9'(release_step_p)) begin
                            gain_d[vidx_q] = gain_q[vidx_q] - 9'(release_step_p);
                        end else begin
                            gain_d[vidx_q] = '0;
                            act_d[vidx_q]  = 1'b0;
                            rel_d[vidx_q]  = 1'b0;
                        end
                    end else begin
                        gain_sum_c = {1'b0, gain_q[vidx_q]} + 10'(attack_step_p);
                        gain_d[vidx_q] = (gain_sum_c >= 10'd256) ? GAIN_FULL : gain_sum_c[8:0];
                    end
`endif
                end
                if (vidx_q == IDX_W'(voices_p - 1)) begin
                    state_d = OUT;
                end else begin
                    vidx_d = vidx_q + IDX_W'(1);
                end
            end
            OUT: begin
                sample_d = acc_q[SUM_W-1 -: width_p];
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sample_o  = sample_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign active_o  = act_q;
endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed self-checking bench for poly_voice_engine (default build, 4 voices, 24-bit).
module tb_poly_voice_engine;
    localparam int V = 4;
    localparam int W = 24;

    logic                clk = 1'b0;
    logic                reset_i = 1'b1;
    logic                evt_valid_i = 1'b0;
    logic                evt_ready_o;
    logic                evt_on_i = 1'b0;
    logic [3:0]          evt_note_i = '0;
    logic [1:0]          mode_i = '0;
    logic                sample_en_i = 1'b0;
    logic signed [W-1:0] sample_o;
    logic                valid_o;
    logic [V-1:0]        active_o;
    logic                overrun_o;

    int errors = 0;
    int checks = 0;

    poly_voice_engine #(
        .voices_p(V), .width_p(W), .acc_width_p(32), .sample_rate_p(48000),
        .attack_step_p(16), .release_step_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
        .evt_on_i(evt_on_i), .evt_note_i(evt_note_i),
        .mode_i(mode_i), .sample_en_i(sample_en_i),
        .sample_o(sample_o), .valid_o(valid_o),
        .active_o(active_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        evt_valid_i = 1'b0;
        sample_en_i = 1'b0;
        reset_i = 1'b1;
        #2;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic send_evt(input logic on, input logic [3:0] note);
        int n = 0;
        while (!evt_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("evt_ready_timeout", evt_ready_o, 1);
        evt_valid_i = 1'b1;
        evt_on_i    = on;
        evt_note_i  = note;
        tick();
        evt_valid_i = 1'b0;
    endtask

    task automatic strobe_check(input logic [1:0] mode, input string tag,
                                input logic signed [63:0] exp);
        int n = 0;
        mode_i      = mode;
        sample_en_i = 1'b1;
        tick();
        sample_en_i = 1'b0;
        while (!valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 5);
        check(tag, sample_o, exp);
    endtask

    initial begin
        int vcount;
        // Reset state.
        #2;
        check("rst_sample", sample_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_active", active_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_ready", evt_ready_o, 1);
        tick();
        reset_i = 1'b0;

        // Strobe with no notes.
        strobe_check(2'd0, "empty_mix", 0);
        check("empty_active", active_o, 0);

        // Note-on 5, saw, two samples.
        send_evt(1'b1, 4'd5);
        check("on5_active", active_o, 4'b0001);
        strobe_check(2'd0, "saw_s0", -2097152);
        strobe_check(2'd0, "saw_s1", -2058705);

        // Retrigger resets phase; square then triangle then silence.
        send_evt(1'b1, 4'd5);
        check("retrig_active", active_o, 4'b0001);
        strobe_check(2'd1, "square_s0", 2097151);
        strobe_check(2'd2, "tri_s1", -2020257);
        strobe_check(2'd3, "silence", 0);
        send_evt(1'b1, 4'd5);
        strobe_check(2'd2, "tri_s0", -2097152);

        // Reset in the middle of ACCUM: no valid afterwards.
        mode_i = 2'd0;
        sample_en_i = 1'b1;
        tick();
        sample_en_i = 1'b0;
        tick();
        reset_i = 1'b1;
        #2;
        check("midrst_active", active_o, 0);
        check("midrst_valid", valid_o, 0);
        tick();
        reset_i = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o) vcount++;
        end
        check("midrst_no_valid", vcount, 0);

        // Allocation, stealing and note-off matching.
        for (int n = 0; n < 5; n++) send_evt(1'b1, 4'(n));
        check("alloc_full", active_o, 4'b1111);
        send_evt(1'b0, 4'd7);
        check("off_nomatch", active_o, 4'b1111);
        send_evt(1'b0, 4'd1);
        check("off_note1", active_o, 4'b1101);
        send_evt(1'b0, 4'd0);
        check("off_stolen_note0", active_o, 4'b1101);
        send_evt(1'b0, 4'd4);
        check("off_note4_voice0", active_o, 4'b1100);
        send_evt(1'b1, 4'd9);
        check("realloc_lowest", active_o, 4'b1101);

        // Overrun and event back-pressure during ACCUM.
        do_reset();
        mode_i = 2'd0;
        sample_en_i = 1'b1;
        tick();
        sample_en_i = 1'b0;
        evt_valid_i = 1'b1;
        evt_on_i    = 1'b1;
        evt_note_i  = 4'd2;
        check("accum_ready", evt_ready_o, 0);
        tick();
        sample_en_i = 1'b1;
        tick();
        check("overrun_pulse", overrun_o, 1);
        sample_en_i = 1'b0;
        tick();
        check("overrun_clear", overrun_o, 0);
        check("evt_held", active_o, 0);
        tick();
        check("valid_early", valid_o, 0);
        tick();
        check("valid_on_time", valid_o, 1);
        check("ovr_sample", sample_o, 0);
        check("ready_back", evt_ready_o, 1);
        check("evt_still_held", active_o, 0);
        tick();
        evt_valid_i = 1'b0;
        check("evt_applied", active_o, 4'b0001);
        check("valid_single_cycle", valid_o, 0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o) vcount++;
        end
        check("no_extra_valid", vcount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
